alarm_controller: RTL
=====================

# alarm_controller

Sequencing controller for the alarm datapath. It drives the minute and hour increment strobes of the alarm-time counter from held set buttons, with auto-repeat. It compares the 24-bit running clock time stamp against the 24-bit alarm time stamp, both in hundredths of a second since midnight. It runs the arm / ring / snooze / stop state machine and produces the buzzer drive pattern for the top-level clock.

## Interface
Parameters:
- MAX_COUNT, 8640000: time-stamp modulus (hundredths per day).
- CLK_PER_CS, 50000: i_Clk_5MHz cycles per hundredth-second tick.
- SNOOZE_CS, 54000: snooze length in hundredths (9 min).
- RING_CS, 6000: ring timeout in hundredths (60 s).
- BEEP_CS, 50: buzzer on/off half-period in hundredths.
- REPEAT_DELAY_CS, 50: hold time before auto-repeat starts.
- REPEAT_RATE_CS, 10: auto-repeat interval.

Ports:
- i_Clk_5MHz  in  1  sole clock.
- i_Reset_n  in  1  asynchronous, active-low reset.
- i_Time_Stamp  in  24  current clock time, 0..MAX_COUNT-1.
- i_Alarm_Time_Stamp  in  24  alarm setting, 0..MAX_COUNT-1.
- i_Set_Mode  in  1  level; alarm-set buttons enabled.
- i_Minutes_Btn, i_Hours_Btn  in  1 each  debounced levels.
- i_Arm_Toggle, i_Snooze, i_Stop  in  1 each  single-cycle pulses.
- o_Minutes_Inc, o_Hours_Inc  out  1 each  single-cycle increment strobes to the alarm-time counter.
- o_Armed  out  1  state is ARMED, RINGING or SNOOZE.
- o_Ringing  out  1  state is RINGING.
- o_Snoozing  out  1  state is SNOOZE.
- o_Buzzer  out  1  beep pattern.

## Operation
- Tick prescaler: counts 0..CLK_PER_CS-1. The internal tick pulses one cycle at the terminal count. It runs freely from reset.
- States: DISARMED, ARMED, RINGING, SNOOZE. Reset state is DISARMED.
- Trigger condition: i_Time_Stamp equals the target and i_Time_Stamp differs from its value one cycle earlier (previous-stamp register). This gives exactly one trigger per match, even if the stamp is held.
  - Target in ARMED is i_Alarm_Time_Stamp.
  - Target in SNOOZE is the internal 24-bit snooze register.
- DISARMED: i_Arm_Toggle goes to ARMED.
- ARMED:
  - Trigger goes to RINGING.
  - i_Arm_Toggle goes to DISARMED.
- RINGING:
  - i_Stop goes to ARMED (rearmed for the next day).
  - i_Snooze goes to SNOOZE and loads the snooze register with i_Time_Stamp + SNOOZE_CS. If the sum is ≥ MAX_COUNT, MAX_COUNT is subtracted. Use a 25-bit intermediate.
  - i_Arm_Toggle goes to DISARMED.
  - Ring counter reaching RING_CS ticks goes to ARMED.
- SNOOZE:
  - Trigger goes to RINGING.
  - i_Stop goes to ARMED.
  - i_Arm_Toggle goes to DISARMED.
- Simultaneous pulses: priority is i_Stop > i_Snooze > i_Arm_Toggle > trigger/timeout. Pulses that are not valid in the current state are ignored.
- Ring counter: cleared on every entry to RINGING; increments on each tick while RINGING.
- Buzzer:
  - The phase bit is set on RINGING entry and toggles every BEEP_CS ticks.
  - o_Buzzer = RINGING & phase.
  - o_Buzzer is 0 in every other state.
- Set buttons (minutes and hours handled independently, same rules):
  - Buttons are active only when i_Set_Mode=1 and state ≠ RINGING.
  - A rising edge emits one o_*_Inc strobe.
  - While the button is held, one strobe is emitted after REPEAT_DELAY_CS ticks, then one every REPEAT_RATE_CS ticks.
  - Release, i_Set_Mode=0, or entry to RINGING clears the repeat counter. No strobe is emitted on release.
  - If both buttons rise in the same cycle, both strobes are emitted in that cycle.

## Timing
- All outputs are registered.
- Reset values: o_Minutes_Inc=0, o_Hours_Inc=0, o_Armed=0, o_Ringing=0, o_Snoozing=0, o_Buzzer=0. The prescaler, ring, beep, repeat and snooze registers are reset to 0. The previous-stamp register is reset to 0.
- Trigger latency: o_Ringing rises 1 cycle after the cycle in which i_Time_Stamp changes to the target. o_Buzzer rises in that same cycle.
- Pulse latency: a state change appears on the outputs 1 cycle after the input pulse.
- Button latency: o_*_Inc goes high 1 cycle after the rising edge and stays high for exactly 1 cycle.
- Wrap-around:
  - Alarm at 0 triggers when the stamp changes from MAX_COUNT-1 to 0.
  - A snooze sum at exactly MAX_COUNT wraps to 0.
- Async reset mid-ring: all outputs drop immediately. After reset the state is DISARMED.

## Test plan
Parameters for all scenarios: CLK_PER_CS=4, RING_CS=20, BEEP_CS=2, REPEAT_DELAY_CS=5, REPEAT_RATE_CS=2, SNOOZE_CS=30.
- Arm + trigger: arm, alarm=1000, step stamp 998→999→1000 → o_Ringing=1 one cycle after the stamp reaches 1000. o_Buzzer is high for 8 cycles, low for 8 cycles, repeating. No retrigger while the stamp is held at 1000.
- Timeout: let it ring with no input → o_Ringing falls after 80 cycles and state returns to ARMED (o_Armed=1).
- Snooze wrap: ring at stamp 8639990, pulse i_Snooze → snooze register = 20, o_Snoozing=1. Stamp reaching 20 → RINGING.
- Priority: i_Stop and i_Snooze in the same cycle while RINGING → ARMED, o_Snoozing stays 0. i_Arm_Toggle in ARMED → DISARMED, and a later stamp match produces no ring.
- Auto-repeat: i_Set_Mode=1, hold i_Minutes_Btn 60 cycles → strobes at cycle 1, about 20 and about 28, then every 8 cycles. i_Hours_Btn rising in the same cycle as i_Minutes_Btn → both strobes in the same cycle. Buttons ignored while RINGING.
- Reset: assert i_Reset_n=0 mid-ring → all outputs 0 asynchronously, state DISARMED after release.

Source files
------------

// File: rtl/alarm_controller.sv
// Alarm sequencing controller: arm/ring/snooze/stop FSM, time-stamp match,
// buzzer beep pattern and auto-repeating alarm-set strobes.
module alarm_controller #(
    parameter int unsigned MAX_COUNT       = 8640000,
    parameter int unsigned CLK_PER_CS      = 50000,
    parameter int unsigned SNOOZE_CS       = 54000,
    parameter int unsigned RING_CS         = 6000,
    parameter int unsigned BEEP_CS         = 50,
    parameter int unsigned REPEAT_DELAY_CS = 50,
    parameter int unsigned REPEAT_RATE_CS  = 10
) (
    input  logic        i_Clk_5MHz,
    input  logic        i_Reset_n,
    input  logic [23:0] i_Time_Stamp,
    input  logic [23:0] i_Alarm_Time_Stamp,
    input  logic        i_Set_Mode,
    input  logic        i_Minutes_Btn,
    input  logic        i_Hours_Btn,
    input  logic        i_Arm_Toggle,
    input  logic        i_Snooze,
    input  logic        i_Stop,
    output logic        o_Minutes_Inc,
    output logic        o_Hours_Inc,
    output logic        o_Armed,
    output logic        o_Ringing,
    output logic        o_Snoozing,
    output logic        o_Buzzer
);

    localparam int unsigned TS_W    = 24;
    localparam int unsigned SUM_W   = TS_W + 1;
    localparam int unsigned PRE_W   = (CLK_PER_CS > 1) ? $clog2(CLK_PER_CS) : 1;
    localparam int unsigned RING_W  = (RING_CS > 1) ? $clog2(RING_CS) : 1;
    localparam int unsigned BEEP_W  = (BEEP_CS > 1) ? $clog2(BEEP_CS) : 1;
    localparam int unsigned REP_MAX = (REPEAT_DELAY_CS > REPEAT_RATE_CS) ?
                                      REPEAT_DELAY_CS : REPEAT_RATE_CS;
    localparam int unsigned REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_RINGING  = 2'd2,
        ST_SNOOZE   = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [PRE_W-1:0]    pre_cnt;
    logic                tick;
    logic [TS_W-1:0]     prev_stamp;
    logic [TS_W-1:0]     snooze_reg;
    logic [SUM_W-1:0]    snooze_sum;
    logic [SUM_W-1:0]    snooze_wrap;
    logic [RING_W-1:0]   ring_cnt;
    logic [BEEP_W-1:0]   beep_cnt;
    logic                phase;
    logic                phase_nxt;
    logic                ring_last;
    logic                beep_last;
    logic                trigger;
    logic                ring_timeout;
    logic                ring_entry;
    logic                snooze_load;

    logic [1:0]          btn;
    logic [1:0]          btn_prev;
    logic                btn_active;
    logic [1:0]          strobe_c;
    logic [REP_W-1:0]    rep_cnt         [2];
    logic [REP_W-1:0]    rep_cnt_nxt     [2];
    logic [1:0]          rep_started;
    logic [1:0]          rep_started_nxt;

    // Free-running hundredth-second prescaler
    assign tick = (pre_cnt == PRE_W'(CLK_PER_CS - 1));

    always_ff @(posedge i_Clk_5MHz or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
        end
    end

    // Snooze target wraps past midnight
    assign snooze_sum  = SUM_W'(i_Time_Stamp) + SUM_W'(SNOOZE_CS);
    assign snooze_wrap = (snooze_sum >= SUM_W'(MAX_COUNT)) ?
                         snooze_sum - SUM_W'(MAX_COUNT) : snooze_sum;

    assign ring_last = (ring_cnt == RING_W'(RING_CS - 1));
    assign beep_last = (beep_cnt == BEEP_W'(BEEP_CS - 1));

    always_ff @(posedge i_Clk_5MHz or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state <= ST_DISARMED;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, trigger and buzzer phase; stop > snooze > arm toggle > trigger/timeout
    always_comb begin
        state_nxt    = state;
        trigger      = 1'b0;
        ring_timeout = 1'b0;
        ring_entry   = 1'b0;
        snooze_load  = 1'b0;
        phase_nxt    = phase;

        if (i_Time_Stamp != prev_stamp) begin
            if (state == ST_SNOOZE) begin
                trigger = (i_Time_Stamp == snooze_reg);
            end else begin
                trigger = (i_Time_Stamp == i_Alarm_Time_Stamp);
            end
        end
        ring_timeout = (state == ST_RINGING) && tick && ring_last;

        case (state)
            ST_DISARMED: begin
                if (i_Arm_Toggle) state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
                if (i_Arm_Toggle)  state_nxt = ST_DISARMED;
                else if (trigger)  state_nxt = ST_RINGING;
            end
            ST_RINGING: begin
                if (i_Stop)            state_nxt = ST_ARMED;
                else if (i_Snooze)     state_nxt = ST_SNOOZE;
                else if (i_Arm_Toggle) state_nxt = ST_DISARMED;
                else if (ring_timeout) state_nxt = ST_ARMED;
            end
            ST_SNOOZE: begin
                if (i_Stop)            state_nxt = ST_ARMED;
                else if (i_Arm_Toggle) state_nxt = ST_DISARMED;
                else if (trigger)      state_nxt = ST_RINGING;
            end
            default: state_nxt = ST_DISARMED;
        endcase

        ring_entry  = (state_nxt == ST_RINGING) && (state != ST_RINGING);
        snooze_load = (state == ST_RINGING) && (state_nxt == ST_SNOOZE);

        if (ring_entry) begin
            phase_nxt = 1'b1;
        end else if ((state == ST_RINGING) && tick && beep_last) begin
            phase_nxt = ~phase;
        end
    end

    // Ring timeout, beep timing, snooze target and stamp history
    always_ff @(posedge i_Clk_5MHz or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            ring_cnt   <= '0;
            beep_cnt   <= '0;
            phase      <= 1'b0;
            snooze_reg <= '0;
            prev_stamp <= '0;
        end else begin
            prev_stamp <= i_Time_Stamp;
            phase      <= phase_nxt;
            if (ring_entry) begin
                ring_cnt <= '0;
                beep_cnt <= '0;
            end else if ((state == ST_RINGING) && tick) begin
                ring_cnt <= ring_last ? '0 : ring_cnt + RING_W'(1);
                beep_cnt <= beep_last ? '0 : beep_cnt + BEEP_W'(1);
            end
            if (snooze_load) begin
                snooze_reg <= TS_W'(snooze_wrap);
            end
        end
    end

    assign btn        = {i_Hours_Btn, i_Minutes_Btn};
    assign btn_active = i_Set_Mode && (state != ST_RINGING) && (state_nxt != ST_RINGING);

    // Per-button edge strobe plus delayed auto-repeat; index 0 = minutes, 1 = hours
    always_comb begin
        strobe_c        = '0;
        rep_started_nxt = rep_started;
        for (int i = 0; i < 2; i++) begin
            rep_cnt_nxt[i] = rep_cnt[i];
            if (!btn_active || !btn[i]) begin
                rep_cnt_nxt[i]     = '0;
                rep_started_nxt[i] = 1'b0;
            end else if (!btn_prev[i]) begin
                strobe_c[i]        = 1'b1;
                rep_cnt_nxt[i]     = '0;
                rep_started_nxt[i] = 1'b0;
            end else if (tick) begin
                if (!rep_started[i]) begin
                    if (rep_cnt[i] == REP_W'(REPEAT_DELAY_CS - 1)) begin
                        strobe_c[i]        = 1'b1;
                        rep_cnt_nxt[i]     = '0;
                        rep_started_nxt[i] = 1'b1;
                    end else begin
                        rep_cnt_nxt[i] = rep_cnt[i] + REP_W'(1);
                    end
                end else begin
                    if (rep_cnt[i] == REP_W'(REPEAT_RATE_CS - 1)) begin
                        strobe_c[i]    = 1'b1;
                        rep_cnt_nxt[i] = '0;
                    end else begin
                        rep_cnt_nxt[i] = rep_cnt[i] + REP_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge i_Clk_5MHz or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            btn_prev    <= '0;
            rep_started <= '0;
            for (int i = 0; i < 2; i++) begin
                rep_cnt[i] <= '0;
            end
        end else begin
            btn_prev    <= btn;
            rep_started <= rep_started_nxt;
            for (int i = 0; i < 2; i++) begin
                rep_cnt[i] <= rep_cnt_nxt[i];
            end
        end
    end

    // Registered outputs, driven from next-state values
    always_ff @(posedge i_Clk_5MHz or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            o_Minutes_Inc <= 1'b0;
            o_Hours_Inc   <= 1'b0;
            o_Armed       <= 1'b0;
            o_Ringing     <= 1'b0;
            o_Snoozing    <= 1'b0;
            o_Buzzer      <= 1'b0;
        end else begin
            o_Minutes_Inc <= strobe_c[0];
            o_Hours_Inc   <= strobe_c[1];
            o_Armed       <= (state_nxt != ST_DISARMED);
            o_Ringing     <= (state_nxt == ST_RINGING);
            o_Snoozing    <= (state_nxt == ST_SNOOZE);
            o_Buzzer      <= (state_nxt == ST_RINGING) && phase_nxt;
        end
    end

endmodule
